silent_lpf: RTL and testbench

Per-channel slew-rate limiter ("silent mode" filter) between the duty/phase register bank and the PWM generators. Once per ultrasound period, on a START pulse, each channel's output duty and phase move toward their targets by at most STEP counts. This removes abrupt amplitude and phase jumps that cause audible noise. Phase is treated as circular modulo the channel's CYCLE.

---
 rtl/silent_lpf.sv | 132 +++++++++++++
 tb/tb_silent_lpf.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/silent_lpf.sv
// Per-channel slew-rate limiter: on each START rising edge, walks every channel once and moves
// DUTY_S/PHASE_S toward DUTY/PHASE by at most STEP. Define SILENT_LPF_PHASE_WRAP_EN for circular phase.
module silent_lpf #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 249
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   ENABLE,
    input  logic                   START,
    input  logic [WIDTH-1:0]       STEP,
    input  logic [DEPTH*WIDTH-1:0] CYCLE,
    input  logic [DEPTH*WIDTH-1:0] DUTY,
    input  logic [DEPTH*WIDTH-1:0] PHASE,
    output logic [DEPTH*WIDTH-1:0] DUTY_S,
    output logic [DEPTH*WIDTH-1:0] PHASE_S
);
    localparam int SW = WIDTH + 2;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state, state_next;
    logic [IW-1:0]  idx;
    logic           start_prev;
    logic           start_rise;
    logic [WIDTH-1:0] cyc, cur_duty, cur_phase, tgt_duty, tgt_phase;
    logic [WIDTH-1:0] duty_new, phase_new;

    function automatic logic signed [SW-1:0] ext(input logic [WIDTH-1:0] v);
        return signed'({2'b00, v});
    endfunction

    // Linear step toward target, snapping when within STEP, saturated to 0..cycle.
    function automatic logic [WIDTH-1:0] slew_lin(input logic [WIDTH-1:0] tgt, input logic [WIDTH-1:0] cur,
                                                  input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c);
        logic signed [SW-1:0] d, mag, res;
        d   = ext(tgt) - ext(cur);
        mag = d[SW-1] ? -d : d;
        if (mag <= ext(s))
            res = ext(tgt);
        else if (d[SW-1])
            res = ext(cur) - ext(s);
        else
            res = ext(cur) + ext(s);
        if (res[SW-1])
            res = '0;
        else if (res > ext(c))
            res = ext(c);
        return res[WIDTH-1:0];
    endfunction

`ifdef SILENT_LPF_PHASE_WRAP_EN
    // Shortest circular path; a target equal to the cycle is still reached exactly via the snap.
    function automatic logic [WIDTH-1:0] slew_wrap(input logic [WIDTH-1:0] tgt, input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c);
        logic signed [SW-1:0] raw, f, dist, res;
        logic up;
        raw = ext(tgt) - ext(cur);
        if (raw[SW-1])
            f = raw + ext(c);
        else if (raw >= ext(c))
            f = raw - ext(c);
        else
            f = raw;
        up   = (f <= (ext(c) >>> 1));
        dist = up ? f : (ext(c) - f);
        if (dist <= ext(s)) begin
            res = ext(tgt);
        end else if (up) begin
            res = ext(cur) + ext(s);
            if (res >= ext(c))
                res = res - ext(c);
        end else begin
            res = ext(cur) - ext(s);
            if (res[SW-1])
                res = res + ext(c);
        end
        return res[WIDTH-1:0];
    endfunction
`endif

    assign start_rise = START & ~start_prev;

    always_comb begin
        cyc       = CYCLE[idx*WIDTH +: WIDTH];
        cur_duty  = DUTY_S[idx*WIDTH +: WIDTH];
        cur_phase = PHASE_S[idx*WIDTH +: WIDTH];
        tgt_duty  = DUTY[idx*WIDTH +: WIDTH];
        tgt_phase = PHASE[idx*WIDTH +: WIDTH];
        duty_new  = slew_lin(tgt_duty, cur_duty, STEP, cyc);
`ifdef SILENT_LPF_PHASE_WRAP_EN
        phase_new = slew_wrap(tgt_phase, cur_phase, STEP, cyc);
`else
        phase_new = slew_lin(tgt_phase, cur_phase, STEP, cyc);
`endif
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start_rise) state_next = RUN;
            RUN:  if (idx == LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (!ENABLE)
            state_next = IDLE;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            idx        <= '0;
            start_prev <= 1'b0;
            DUTY_S     <= '0;
            PHASE_S    <= '0;
        end else begin
            start_prev <= START;
            state      <= state_next;
            if (!ENABLE) begin
                DUTY_S  <= DUTY;
                PHASE_S <= PHASE;
                idx     <= '0;
            end else if (state == RUN) begin
                DUTY_S[idx*WIDTH +: WIDTH]  <= duty_new;
                PHASE_S[idx*WIDTH +: WIDTH] <= phase_new;
                idx <= (idx == LAST) ? '0 : idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_silent_lpf.sv
// Directed self-checking bench for silent_lpf; expectations follow SILENT_LPF_PHASE_WRAP_EN if defined.
module tb_silent_lpf;
    localparam int W = 13;
    localparam int D = 249;

    logic           CLK = 1'b0;
    logic           RST_N;
    logic           ENABLE;
    logic           START;
    logic [W-1:0]   STEP;
    logic [D*W-1:0] CYCLE, DUTY, PHASE, DUTY_S, PHASE_S;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] tgt_d [D];
    logic [W-1:0] tgt_p [D];

    silent_lpf #(.WIDTH(W), .DEPTH(D)) dut (
        .CLK(CLK), .RST_N(RST_N), .ENABLE(ENABLE), .START(START), .STEP(STEP),
        .CYCLE(CYCLE), .DUTY(DUTY), .PHASE(PHASE), .DUTY_S(DUTY_S), .PHASE_S(PHASE_S)
    );

    always #5 CLK = ~CLK;

    task automatic set_all(input int d, input int p);
        for (int i = 0; i < D; i++) begin
            DUTY[i*W +: W]  = W'(d);
            PHASE[i*W +: W] = W'(p);
        end
    endtask

    task automatic run_pass();
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (D + 3) @(negedge CLK);
    endtask

    task automatic run_passes(input int n);
        for (int k = 0; k < n; k++) run_pass();
    endtask

    // Force outputs to known values through bypass, then re-enable filtering.
    task automatic preload(input int d, input int p);
        set_all(d, p);
        ENABLE = 1'b0;
        @(negedge CLK);
        ENABLE = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RST_N = 1'b0; ENABLE = 1'b1; START = 1'b0; STEP = W'(100);
        for (int i = 0; i < D; i++) CYCLE[i*W +: W] = W'(5000);
        set_all(2500, 0);
        repeat (3) @(negedge CLK);
        for (int i = 0; i < D; i += 62) begin
            checks++;
            if (DUTY_S[i*W +: W] !== W'(0) || PHASE_S[i*W +: W] !== W'(0)) begin
                errors++;
                $display("FAIL reset ch%0d duty_s=%0d phase_s=%0d want 0/0", i, DUTY_S[i*W +: W], PHASE_S[i*W +: W]);
            end
        end
        RST_N = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_rise();
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        checks++;
        if (DUTY_S[0 +: W] !== W'(0)) begin
            errors++; $display("FAIL latency_ch0_early got=%0d want=0", DUTY_S[0 +: W]);
        end
        @(negedge CLK);
        checks++;
        if (DUTY_S[0 +: W] !== W'(100) || DUTY_S[W +: W] !== W'(0)) begin
            errors++; $display("FAIL latency_ch0_ch1 got=%0d,%0d want=100,0", DUTY_S[0 +: W], DUTY_S[W +: W]);
        end
        repeat (D + 2) @(negedge CLK);
        for (int i = 0; i < D; i++) begin
            checks++;
            if (DUTY_S[i*W +: W] !== W'(100)) begin
                errors++; $display("FAIL rise_pass1 ch%0d got=%0d want=100", i, DUTY_S[i*W +: W]);
            end
        end
        run_passes(24);
        for (int i = 0; i < D; i++) begin
            checks++;
            if (DUTY_S[i*W +: W] !== W'(2500)) begin
                errors++; $display("FAIL rise_pass25 ch%0d got=%0d want=2500", i, DUTY_S[i*W +: W]);
            end
        end
        run_passes(2);
        set_all(0, 0);
        repeat (300) @(negedge CLK);
        for (int i = 0; i < D; i += 31) begin
            checks++;
            if (DUTY_S[i*W +: W] !== W'(2500)) begin
                errors++; $display("FAIL hold_between_passes ch%0d got=%0d want=2500", i, DUTY_S[i*W +: W]);
            end
        end
    endtask

    task automatic test_random_retarget();
        preload(0, 0);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < D; i++) begin
                tgt_d[i] = W'($urandom_range(5000));
                tgt_p[i] = W'($urandom_range(5000));
                DUTY[i*W +: W]  = tgt_d[i];
                PHASE[i*W +: W] = tgt_p[i];
            end
            run_passes(55);
            for (int i = 0; i < D; i++) begin
                checks++;
                if (DUTY_S[i*W +: W] !== tgt_d[i] || PHASE_S[i*W +: W] !== tgt_p[i]) begin
                    errors++;
                    $display("FAIL random_r%0d ch%0d duty_s=%0d phase_s=%0d want %0d/%0d", r, i,
                             DUTY_S[i*W +: W], PHASE_S[i*W +: W], tgt_d[i], tgt_p[i]);
                end
            end
        end
    endtask

    task automatic test_snap_boundary();
        preload(4950, 4950);
        set_all(5000, 5000);
        run_pass();
        for (int i = 0; i < D; i += 31) begin
            checks++;
            if (DUTY_S[i*W +: W] !== W'(5000) || PHASE_S[i*W +: W] !== W'(5000)) begin
                errors++;
                $display("FAIL snap_boundary ch%0d duty_s=%0d phase_s=%0d want 5000/5000", i, DUTY_S[i*W +: W], PHASE_S[i*W +: W]);
            end
        end
    endtask

    task automatic test_phase_wrap();
        int e1, e10;
`ifdef SILENT_LPF_PHASE_WRAP_EN
        e1 = 50; e10 = 50;
`else
        e1 = 4850; e10 = 3950;
`endif
        preload(0, 4950);
        set_all(0, 50);
        run_pass();
        checks++;
        if (PHASE_S[7*W +: W] !== W'(e1)) begin
            errors++; $display("FAIL wrap_pass1 got=%0d want=%0d", PHASE_S[7*W +: W], e1);
        end
        run_passes(9);
        checks++;
        if (PHASE_S[200*W +: W] !== W'(e10)) begin
            errors++; $display("FAIL wrap_pass10 got=%0d want=%0d", PHASE_S[200*W +: W], e10);
        end
        run_passes(40);
        for (int i = 0; i < D; i += 31) begin
            checks++;
            if (PHASE_S[i*W +: W] !== W'(50)) begin
                errors++; $display("FAIL wrap_pass50 ch%0d got=%0d want=50", i, PHASE_S[i*W +: W]);
            end
        end
    endtask

    task automatic test_busy_and_bypass();
        preload(0, 0);
        set_all(1000, 1000);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (10) @(negedge CLK);
        START = 1'b1;
        repeat (2) @(negedge CLK);
        START = 1'b0;
        repeat (D) @(negedge CLK);
        for (int i = 0; i < D; i += 8) begin
            checks++;
            if (DUTY_S[i*W +: W] !== W'(100) || PHASE_S[i*W +: W] !== W'(100)) begin
                errors++;
                $display("FAIL start_while_busy ch%0d duty_s=%0d phase_s=%0d want 100/100", i, DUTY_S[i*W +: W], PHASE_S[i*W +: W]);
            end
        end
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (20) @(negedge CLK);
        set_all(1234, 1234);
        ENABLE = 1'b0;
        @(negedge CLK);
        for (int i = 0; i < D; i += 8) begin
            checks++;
            if (DUTY_S[i*W +: W] !== W'(1234) || PHASE_S[i*W +: W] !== W'(1234)) begin
                errors++;
                $display("FAIL bypass ch%0d duty_s=%0d phase_s=%0d want 1234/1234", i, DUTY_S[i*W +: W], PHASE_S[i*W +: W]);
            end
        end
        ENABLE = 1'b1;
        set_all(1500, 1500);
        repeat (D + 5) @(negedge CLK);
        checks++;
        if (DUTY_S[(D-1)*W +: W] !== W'(1234)) begin
            errors++; $display("FAIL abort_no_resume got=%0d want=1234", DUTY_S[(D-1)*W +: W]);
        end
        run_pass();
        checks++;
        if (DUTY_S[(D-1)*W +: W] !== W'(1334) || DUTY_S[0 +: W] !== W'(1334)) begin
            errors++; $display("FAIL resume_pass got=%0d,%0d want=1334,1334", DUTY_S[0 +: W], DUTY_S[(D-1)*W +: W]);
        end
    endtask

    initial begin
        test_reset();
        test_rise();
        test_random_retarget();
        test_snap_boundary();
        test_phase_wrap();
        test_busy_and_bypass();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
